// File: rtl/fft_top.sv
// 32-point real-input radix-2 DIT FFT power analyser.
// Seven register ranks: sample capture, five butterfly stages, then power/level.
// One frame per clock; bins 0..16 are reported, 17..31 are mirror images and dropped.
module fft_top (
    input  logic        clk,
    input  logic        reset,
    input  logic        freeze,
    input  logic [7:0]  pw_x0_r_in,
    input  logic [7:0]  pw_x1_r_in,
    input  logic [7:0]  pw_x2_r_in,
    input  logic [7:0]  pw_x3_r_in,
    input  logic [7:0]  pw_x4_r_in,
    input  logic [7:0]  pw_x5_r_in,
    input  logic [7:0]  pw_x6_r_in,
    input  logic [7:0]  pw_x7_r_in,
    input  logic [7:0]  pw_x8_r_in,
    input  logic [7:0]  pw_x9_r_in,
    input  logic [7:0]  pw_x10_r_in,
    input  logic [7:0]  pw_x11_r_in,
    input  logic [7:0]  pw_x12_r_in,
    input  logic [7:0]  pw_x13_r_in,
    input  logic [7:0]  pw_x14_r_in,
    input  logic [7:0]  pw_x15_r_in,
    input  logic [7:0]  pw_x16_r_in,
    input  logic [7:0]  pw_x17_r_in,
    input  logic [7:0]  pw_x18_r_in,
    input  logic [7:0]  pw_x19_r_in,
    input  logic [7:0]  pw_x20_r_in,
    input  logic [7:0]  pw_x21_r_in,
    input  logic [7:0]  pw_x22_r_in,
    input  logic [7:0]  pw_x23_r_in,
    input  logic [7:0]  pw_x24_r_in,
    input  logic [7:0]  pw_x25_r_in,
    input  logic [7:0]  pw_x26_r_in,
    input  logic [7:0]  pw_x27_r_in,
    input  logic [7:0]  pw_x28_r_in,
    input  logic [7:0]  pw_x29_r_in,
    input  logic [7:0]  pw_x30_r_in,
    input  logic [7:0]  pw_x31_r_in,
    output logic [34:0] pwr_0,
    output logic [34:0] pwr_1,
    output logic [34:0] pwr_2,
    output logic [34:0] pwr_3,
    output logic [34:0] pwr_4,
    output logic [34:0] pwr_5,
    output logic [34:0] pwr_6,
    output logic [34:0] pwr_7,
    output logic [34:0] pwr_8,
    output logic [34:0] pwr_9,
    output logic [34:0] pwr_10,
    output logic [34:0] pwr_11,
    output logic [34:0] pwr_12,
    output logic [34:0] pwr_13,
    output logic [34:0] pwr_14,
    output logic [34:0] pwr_15,
    output logic [34:0] pwr_16,
    output logic [3:0]  pwr_dec_0,
    output logic [3:0]  pwr_dec_1,
    output logic [3:0]  pwr_dec_2,
    output logic [3:0]  pwr_dec_3,
    output logic [3:0]  pwr_dec_4,
    output logic [3:0]  pwr_dec_5,
    output logic [3:0]  pwr_dec_6,
    output logic [3:0]  pwr_dec_7,
    output logic [3:0]  pwr_dec_8,
    output logic [3:0]  pwr_dec_9,
    output logic [3:0]  pwr_dec_10,
    output logic [3:0]  pwr_dec_11,
    output logic [3:0]  pwr_dec_12,
    output logic [3:0]  pwr_dec_13,
    output logic [3:0]  pwr_dec_14,
    output logic [3:0]  pwr_dec_15,
    output logic [3:0]  pwr_dec_16
);

    localparam int unsigned N  = 32;
    localparam int unsigned NS = 5;
    localparam int unsigned NB = 17;
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 9;
    localparam int unsigned IW = 18;
    localparam int unsigned PW = 35;
    localparam int unsigned LW = 4;
    localparam int unsigned PR = TW + IW;
    localparam int unsigned SW = 2 * IW;

    // round(128*cos(2*pi*k/32)) and round(128*sin(2*pi*k/32)), half away from zero
    localparam logic signed [TW-1:0] COS_T [16] = '{
        9'sd128, 9'sd126, 9'sd118, 9'sd106, 9'sd91, 9'sd71, 9'sd49, 9'sd25,
        9'sd0, -9'sd25, -9'sd49, -9'sd71, -9'sd91, -9'sd106, -9'sd118, -9'sd126};
    localparam logic signed [TW-1:0] SIN_T [16] = '{
        9'sd0, 9'sd25, 9'sd49, 9'sd71, 9'sd91, 9'sd106, 9'sd118, 9'sd126,
        9'sd128, 9'sd126, 9'sd118, 9'sd106, 9'sd91, 9'sd71, 9'sd49, 9'sd25};

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        logic [4:0] r;
        r = '0;
        for (int unsigned b = 0; b < 5; b++) r[b] = v[4-b];
        return r;
    endfunction

    function automatic logic signed [IW-1:0] cmul_re(input logic signed [TW-1:0] c_r,
                                                      input logic signed [TW-1:0] c_i,
                                                      input logic signed [IW-1:0] v_r,
                                                      input logic signed [IW-1:0] v_i);
        logic signed [PR-1:0] acc;
        acc = PR'(c_r) * PR'(v_r) - PR'(c_i) * PR'(v_i);
        return IW'(acc >>> 7);
    endfunction

    function automatic logic signed [IW-1:0] cmul_im(input logic signed [TW-1:0] c_r,
                                                      input logic signed [TW-1:0] c_i,
                                                      input logic signed [IW-1:0] v_r,
                                                      input logic signed [IW-1:0] v_i);
        logic signed [PR-1:0] acc;
        acc = PR'(c_r) * PR'(v_i) + PR'(c_i) * PR'(v_r);
        return IW'(acc >>> 7);
    endfunction

    // Level = min(15, msb/2 + 1); zero power maps to level 0
    function automatic logic [LW-1:0] level_of(input logic [PW-1:0] p);
        logic [LW-1:0] lv;
        lv = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            if (p[i]) lv = (i / 2 + 1 > 15) ? 4'd15 : LW'(i / 2 + 1);
        end
        return lv;
    endfunction

    logic [DW-1:0]        x_in [N];
    logic signed [DW-1:0] x_q  [N];

    assign x_in[0]  = pw_x0_r_in;   assign x_in[1]  = pw_x1_r_in;
    assign x_in[2]  = pw_x2_r_in;   assign x_in[3]  = pw_x3_r_in;
    assign x_in[4]  = pw_x4_r_in;   assign x_in[5]  = pw_x5_r_in;
    assign x_in[6]  = pw_x6_r_in;   assign x_in[7]  = pw_x7_r_in;
    assign x_in[8]  = pw_x8_r_in;   assign x_in[9]  = pw_x9_r_in;
    assign x_in[10] = pw_x10_r_in;  assign x_in[11] = pw_x11_r_in;
    assign x_in[12] = pw_x12_r_in;  assign x_in[13] = pw_x13_r_in;
    assign x_in[14] = pw_x14_r_in;  assign x_in[15] = pw_x15_r_in;
    assign x_in[16] = pw_x16_r_in;  assign x_in[17] = pw_x17_r_in;
    assign x_in[18] = pw_x18_r_in;  assign x_in[19] = pw_x19_r_in;
    assign x_in[20] = pw_x20_r_in;  assign x_in[21] = pw_x21_r_in;
    assign x_in[22] = pw_x22_r_in;  assign x_in[23] = pw_x23_r_in;
    assign x_in[24] = pw_x24_r_in;  assign x_in[25] = pw_x25_r_in;
    assign x_in[26] = pw_x26_r_in;  assign x_in[27] = pw_x27_r_in;
    assign x_in[28] = pw_x28_r_in;  assign x_in[29] = pw_x29_r_in;
    assign x_in[30] = pw_x30_r_in;  assign x_in[31] = pw_x31_r_in;

    // R0: raw sample capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned j = 0; j < N; j++) x_q[j] <= '0;
        end else if (!freeze) begin
            for (int unsigned j = 0; j < N; j++) x_q[j] <= x_in[j];
        end
    end

    for (genvar s = 0; s < NS; s++) begin : g_stage
        localparam int unsigned M     = 2 << s;
        localparam int unsigned H     = M / 2;
        localparam int unsigned TSTEP = N / M;

        logic signed [IW-1:0] in_re [N];
        logic signed [IW-1:0] in_im [N];
        logic signed [IW-1:0] d_re  [N];
        logic signed [IW-1:0] d_im  [N];
        logic signed [IW-1:0] q_re  [N];
        logic signed [IW-1:0] q_im  [N];
        logic signed [TW-1:0] w_re, w_im;
        logic signed [IW-1:0] t_re, t_im;

        if (s == 0) begin : g_src
            // First stage reads sign-extended samples in bit-reversed order
            always_comb begin
                for (int unsigned j = 0; j < N; j++) begin
                    in_re[j] = {{(IW-DW){x_q[bitrev5(5'(j))][DW-1]}}, x_q[bitrev5(5'(j))]};
                    in_im[j] = '0;
                end
            end
        end else begin : g_src
            // Later stages read the previous rank
            always_comb begin
                for (int unsigned j = 0; j < N; j++) begin
                    in_re[j] = g_stage[s-1].q_re[j];
                    in_im[j] = g_stage[s-1].q_im[j];
                end
            end
        end

        // Butterflies of span M: a+t at k, a-t at k+M/2 with t = W*b
        always_comb begin
            w_re = '0;
            w_im = '0;
            t_re = '0;
            t_im = '0;
            for (int unsigned j = 0; j < N; j++) begin
                d_re[j] = '0;
                d_im[j] = '0;
            end
            for (int unsigned j = 0; j < N; j++) begin
                if ((j % M) < H) begin
                    w_re = COS_T[4'((j % M) * TSTEP)];
                    w_im = -SIN_T[4'((j % M) * TSTEP)];
                    t_re = cmul_re(w_re, w_im, in_re[5'(j + H)], in_im[5'(j + H)]);
                    t_im = cmul_im(w_re, w_im, in_re[5'(j + H)], in_im[5'(j + H)]);
                    d_re[j]           = in_re[j] + t_re;
                    d_im[j]           = in_im[j] + t_im;
                    d_re[5'(j + H)]   = in_re[j] - t_re;
                    d_im[5'(j + H)]   = in_im[j] - t_im;
                end
            end
        end

        // Stage rank register
        always_ff @(posedge clk) begin
            if (!reset) begin
                for (int unsigned j = 0; j < N; j++) begin
                    q_re[j] <= '0;
                    q_im[j] <= '0;
                end
            end else if (!freeze) begin
                for (int unsigned j = 0; j < N; j++) begin
                    q_re[j] <= d_re[j];
                    q_im[j] <= d_im[j];
                end
            end
        end
    end

    logic signed [SW-1:0] sq;
    logic [PW-1:0]        pwr_d [NB];
    logic [LW-1:0]        dec_d [NB];
    logic [PW-1:0]        pwr_q [NB];
    logic [LW-1:0]        dec_q [NB];

    // Bin power and log level from the final stage
    always_comb begin
        sq = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            sq = SW'(g_stage[NS-1].q_re[k]) * SW'(g_stage[NS-1].q_re[k])
               + SW'(g_stage[NS-1].q_im[k]) * SW'(g_stage[NS-1].q_im[k]);
            pwr_d[k] = PW'(sq);
            dec_d[k] = level_of(PW'(sq));
        end
    end

    // R6: output rank
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NB; k++) begin
                pwr_q[k] <= '0;
                dec_q[k] <= '0;
            end
        end else if (!freeze) begin
            for (int unsigned k = 0; k < NB; k++) begin
                pwr_q[k] <= pwr_d[k];
                dec_q[k] <= dec_d[k];
            end
        end
    end

    assign pwr_0  = pwr_q[0];   assign pwr_dec_0  = dec_q[0];
    assign pwr_1  = pwr_q[1];   assign pwr_dec_1  = dec_q[1];
    assign pwr_2  = pwr_q[2];   assign pwr_dec_2  = dec_q[2];
    assign pwr_3  = pwr_q[3];   assign pwr_dec_3  = dec_q[3];
    assign pwr_4  = pwr_q[4];   assign pwr_dec_4  = dec_q[4];
    assign pwr_5  = pwr_q[5];   assign pwr_dec_5  = dec_q[5];
    assign pwr_6  = pwr_q[6];   assign pwr_dec_6  = dec_q[6];
    assign pwr_7  = pwr_q[7];   assign pwr_dec_7  = dec_q[7];
    assign pwr_8  = pwr_q[8];   assign pwr_dec_8  = dec_q[8];
    assign pwr_9  = pwr_q[9];   assign pwr_dec_9  = dec_q[9];
    assign pwr_10 = pwr_q[10];  assign pwr_dec_10 = dec_q[10];
    assign pwr_11 = pwr_q[11];  assign pwr_dec_11 = dec_q[11];
    assign pwr_12 = pwr_q[12];  assign pwr_dec_12 = dec_q[12];
    assign pwr_13 = pwr_q[13];  assign pwr_dec_13 = dec_q[13];
    assign pwr_14 = pwr_q[14];  assign pwr_dec_14 = dec_q[14];
    assign pwr_15 = pwr_q[15];  assign pwr_dec_15 = dec_q[15];
    assign pwr_16 = pwr_q[16];  assign pwr_dec_16 = dec_q[16];

endmodule

// File: tb/tb_fft_top.sv
// Scoreboard bench for fft_top: expected spectra are queued at capture and
// retired when the frame reaches the output rank.
module tb_fft_top;

    typedef int frame_t [32];
    typedef struct packed {
        logic [16:0][34:0] p;
        logic [16:0][3:0]  d;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        freeze;
    logic [7:0]  xin [32];
    logic [34:0] pwr [17];
    logic [3:0]  dec [17];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb [$];
    exp_t last;
    int   twr [16];
    int   twi [16];

    fft_top dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .pw_x0_r_in(xin[0]),   .pw_x1_r_in(xin[1]),   .pw_x2_r_in(xin[2]),   .pw_x3_r_in(xin[3]),
        .pw_x4_r_in(xin[4]),   .pw_x5_r_in(xin[5]),   .pw_x6_r_in(xin[6]),   .pw_x7_r_in(xin[7]),
        .pw_x8_r_in(xin[8]),   .pw_x9_r_in(xin[9]),   .pw_x10_r_in(xin[10]), .pw_x11_r_in(xin[11]),
        .pw_x12_r_in(xin[12]), .pw_x13_r_in(xin[13]), .pw_x14_r_in(xin[14]), .pw_x15_r_in(xin[15]),
        .pw_x16_r_in(xin[16]), .pw_x17_r_in(xin[17]), .pw_x18_r_in(xin[18]), .pw_x19_r_in(xin[19]),
        .pw_x20_r_in(xin[20]), .pw_x21_r_in(xin[21]), .pw_x22_r_in(xin[22]), .pw_x23_r_in(xin[23]),
        .pw_x24_r_in(xin[24]), .pw_x25_r_in(xin[25]), .pw_x26_r_in(xin[26]), .pw_x27_r_in(xin[27]),
        .pw_x28_r_in(xin[28]), .pw_x29_r_in(xin[29]), .pw_x30_r_in(xin[30]), .pw_x31_r_in(xin[31]),
        .pwr_0(pwr[0]),   .pwr_1(pwr[1]),   .pwr_2(pwr[2]),   .pwr_3(pwr[3]),
        .pwr_4(pwr[4]),   .pwr_5(pwr[5]),   .pwr_6(pwr[6]),   .pwr_7(pwr[7]),
        .pwr_8(pwr[8]),   .pwr_9(pwr[9]),   .pwr_10(pwr[10]), .pwr_11(pwr[11]),
        .pwr_12(pwr[12]), .pwr_13(pwr[13]), .pwr_14(pwr[14]), .pwr_15(pwr[15]),
        .pwr_16(pwr[16]),
        .pwr_dec_0(dec[0]),   .pwr_dec_1(dec[1]),   .pwr_dec_2(dec[2]),   .pwr_dec_3(dec[3]),
        .pwr_dec_4(dec[4]),   .pwr_dec_5(dec[5]),   .pwr_dec_6(dec[6]),   .pwr_dec_7(dec[7]),
        .pwr_dec_8(dec[8]),   .pwr_dec_9(dec[9]),   .pwr_dec_10(dec[10]), .pwr_dec_11(dec[11]),
        .pwr_dec_12(dec[12]), .pwr_dec_13(dec[13]), .pwr_dec_14(dec[14]), .pwr_dec_15(dec[15]),
        .pwr_dec_16(dec[16])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic int rnd_half(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic int lvl(input longint p);
        longint v;
        int     msb;
        if (p == 0) return 0;
        v   = p;
        msb = 0;
        while (v > 1) begin
            v = v >> 1;
            msb++;
        end
        return (msb / 2 + 1 > 15) ? 15 : msb / 2 + 1;
    endfunction

    // Reference fixed-point DIT FFT, in place
    function automatic exp_t model(input frame_t x);
        int     re [32];
        int     im [32];
        int     m, h, a, b, idx, tr, ti, ar, ai, r;
        longint pw;
        exp_t   e;
        for (int j = 0; j < 32; j++) begin
            r = 0;
            for (int bb = 0; bb < 5; bb++) r = r | (((j >> bb) & 1) << (4 - bb));
            re[j] = x[r];
            im[j] = 0;
        end
        for (int s = 1; s <= 5; s++) begin
            m = 1 << s;
            h = m / 2;
            for (int g = 0; g < 32; g += m) begin
                for (int k = 0; k < h; k++) begin
                    a   = g + k;
                    b   = a + h;
                    idx = k * (32 / m);
                    tr  = (twr[idx] * re[b] - twi[idx] * im[b]) >>> 7;
                    ti  = (twr[idx] * im[b] + twi[idx] * re[b]) >>> 7;
                    ar  = re[a];
                    ai  = im[a];
                    re[a] = ar + tr;
                    im[a] = ai + ti;
                    re[b] = ar - tr;
                    im[b] = ai - ti;
                end
            end
        end
        e = '0;
        for (int k = 0; k < 17; k++) begin
            pw = longint'(re[k]) * re[k] + longint'(im[k]) * im[k];
            e.p[k] = 35'(pw);
            e.d[k] = 4'(lvl(pw));
        end
        return e;
    endfunction

    task automatic rnd_frame(output frame_t f);
        for (int j = 0; j < 32; j++) f[j] = int'($urandom_range(0, 255)) - 128;
    endtask

    // One clock: drive, let the edge happen, update the scoreboard, compare
    task automatic step(input frame_t f, input exp_t e, input logic rst_v, input logic frz_v);
        for (int j = 0; j < 32; j++) xin[j] = 8'(f[j]);
        reset  = rst_v;
        freeze = frz_v;
        @(posedge clk);
        if (!rst_v) begin
            sb.delete();
            last = '0;
        end else if (!frz_v) begin
            sb.push_back(e);
            if (sb.size() == 7) last = sb.pop_front();
        end
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("cyc%0d pwr%0d", cyc, k), 64'(pwr[k]), 64'(last.p[k]));
            chk($sformatf("cyc%0d dec%0d", cyc, k), 64'(dec[k]), 64'(last.d[k]));
        end
    endtask

    frame_t fz, fdc, fimp, falt, ffs, fr;
    exp_t   e_zero, e_dc, e_imp, e_alt, e_fs;

    initial begin
        real pi_v, c, sn;
        pi_v = 3.14159265358979;
        for (int k = 0; k < 16; k++) begin
            c  = 128.0 * $cos(2.0 * pi_v * k / 32.0);
            sn = 128.0 * $sin(2.0 * pi_v * k / 32.0);
            twr[k] = rnd_half(c);
            twi[k] = -rnd_half(sn);
        end
        for (int j = 0; j < 32; j++) begin
            fz[j]   = 0;
            fdc[j]  = 1;
            fimp[j] = (j == 0) ? 100 : 0;
            falt[j] = (j % 2 == 0) ? 1 : -1;
            ffs[j]  = -128;
        end
        e_zero = '0;
        e_dc   = '0;  e_dc.p[0]  = 35'd1024;     e_dc.d[0]  = 4'd6;
        e_alt  = '0;  e_alt.p[16] = 35'd1024;    e_alt.d[16] = 4'd6;
        e_fs   = '0;  e_fs.p[0]  = 35'd16777216; e_fs.d[0]  = 4'd13;
        e_imp  = '0;
        for (int k = 0; k < 17; k++) begin
            e_imp.p[k] = 35'd10000;
            e_imp.d[k] = 4'd7;
        end
        last   = '0;
        reset  = 1'b0;
        freeze = 1'b0;
        for (int j = 0; j < 32; j++) xin[j] = 8'h00;

        // reset, including reset while freeze is high
        step(fdc, e_dc, 1'b0, 1'b0);
        step(fimp, e_imp, 1'b0, 1'b1);

        // directed frames back to back
        step(fz, e_zero, 1'b1, 1'b0);
        step(fdc, e_dc, 1'b1, 1'b0);
        step(fimp, e_imp, 1'b1, 1'b0);
        step(falt, e_alt, 1'b1, 1'b0);
        step(ffs, e_fs, 1'b1, 1'b0);

        // random stream
        for (int i = 0; i < 12; i++) begin
            rnd_frame(fr);
            step(fr, model(fr), 1'b1, 1'b0);
        end

        // freeze for 3 cycles with changing inputs
        for (int i = 0; i < 3; i++) begin
            rnd_frame(fr);
            step(fr, model(fr), 1'b1, 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            rnd_frame(fr);
            step(fr, model(fr), 1'b1, 1'b0);
        end

        // one-edge reset mid-stream, then refill
        rnd_frame(fr);
        step(fr, model(fr), 1'b0, 1'b0);
        step(ffs, e_fs, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            rnd_frame(fr);
            step(fr, model(fr), 1'b1, 1'b0);
        end

        // flush
        for (int i = 0; i < 7; i++) step(fz, e_zero, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
